// File: rtl/repacker_1_to_4_if.sv
// Byte-in / word-out bus bundle for the 1-to-4 repacker.
// master = byte producer and word consumer side, slave = the repacker itself.
interface repacker_1_to_4_if;
    logic        src_start_rqst;
    logic        src_data_vld;
    logic [7:0]  src_input_data;
    logic        src_fin_rqst;
    logic        src_data_rdy;
    logic        sink_word_avail;
    logic        sink_data_rqst;
    logic [31:0] sink_output_data;
    logic [3:0]  sink_output_strb;
    logic        sink_start_rqst;
    logic        sink_fin_rqst;

    modport master (
        output src_start_rqst, src_data_vld, src_input_data, src_fin_rqst,
        input  src_data_rdy,
        input  sink_word_avail, sink_output_data, sink_output_strb,
        input  sink_start_rqst, sink_fin_rqst,
        output sink_data_rqst
    );

    modport slave (
        input  src_start_rqst, src_data_vld, src_input_data, src_fin_rqst,
        output src_data_rdy,
        output sink_word_avail, sink_output_data, sink_output_strb,
        output sink_start_rqst, sink_fin_rqst,
        input  sink_data_rqst
    );
endinterface

// File: rtl/repacker_1_to_4.sv
// Collects a framed byte stream into 32-bit words with strobes and start/fin flags,
// buffered in a small show-ahead FIFO toward the word-wide packet buffer.
module repacker_1_to_4 #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    repacker_1_to_4_if.slave  bus
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = 38;

    logic [31:0] asm_data;
    logic [3:0]  asm_strb;
    logic [1:0]  byte_counter;
    logic        asm_start;

    logic [31:0] base_data, cur_data, nxt_data;
    logic [3:0]  base_strb, cur_strb, nxt_strb;
    logic [1:0]  base_cnt, nxt_cnt;
    logic        base_start, nxt_start;
    logic        accept, push, pop, full, empty;
    logic [ENTRY_W-1:0] push_entry, head;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign bus.src_data_rdy = ~full;

    // Assembly stage: a start pulse restarts the word before the current byte is placed
    always_comb begin
        base_data  = asm_data;
        base_strb  = asm_strb;
        base_cnt   = byte_counter;
        base_start = asm_start;
        if (bus.src_start_rqst) begin
            base_data  = '0;
            base_strb  = '0;
            base_cnt   = '0;
            base_start = 1'b1;
        end

        cur_data = base_data;
        cur_strb = base_strb;
        for (int k = 0; k < 4; k++) begin
            if (base_cnt == 2'(k)) begin
                cur_data[8*k +: 8] = bus.src_input_data;
                cur_strb[k]        = 1'b1;
            end
        end

        accept     = bus.src_data_vld & ~full;
        push       = accept & ((base_cnt == 2'd3) | bus.src_fin_rqst);
        push_entry = {base_start, bus.src_fin_rqst, cur_strb, cur_data};

        nxt_data  = base_data;
        nxt_strb  = base_strb;
        nxt_cnt   = base_cnt;
        nxt_start = base_start;
        if (push) begin
            nxt_data  = '0;
            nxt_strb  = '0;
            nxt_cnt   = '0;
            nxt_start = 1'b0;
        end else if (accept) begin
            nxt_data = cur_data;
            nxt_strb = cur_strb;
            nxt_cnt  = base_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_data     <= '0;
            asm_strb     <= '0;
            byte_counter <= '0;
            asm_start    <= 1'b0;
        end else begin
            asm_data     <= nxt_data;
            asm_strb     <= nxt_strb;
            byte_counter <= nxt_cnt;
            asm_start    <= nxt_start;
        end
    end

    // Word FIFO stage: storage needs no reset since outputs are masked while empty
    assign pop = bus.sink_data_rqst & ~empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];

    assign bus.sink_word_avail  = ~empty;
    assign bus.sink_start_rqst  = head[37];
    assign bus.sink_fin_rqst    = head[36];
    assign bus.sink_output_strb = head[35:32];
    assign bus.sink_output_data = head[31:0];
endmodule

// File: tb/tb_repacker_1_to_4.sv
// Directed bench for repacker_1_to_4: framing, partial-word discard, backpressure
// and asynchronous reset, with hand-computed expected words.
module tb_repacker_1_to_4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    repacker_1_to_4_if bus ();

    repacker_1_to_4 #(.FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic st, input logic fin);
        bus.src_data_vld   = 1'b1;
        bus.src_input_data = b;
        bus.src_start_rqst = st;
        bus.src_fin_rqst   = fin;
        cyc();
        bus.src_data_vld   = 1'b0;
        bus.src_start_rqst = 1'b0;
        bus.src_fin_rqst   = 1'b0;
    endtask

    task automatic pop();
        bus.sink_data_rqst = 1'b1;
        cyc();
        bus.sink_data_rqst = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] d, input logic [3:0] s,
                              input logic st, input logic fin);
        chk({tag, "_avail"}, 32'(bus.sink_word_avail), 32'(1));
        chk({tag, "_data"},  bus.sink_output_data, d);
        chk({tag, "_strb"},  32'(bus.sink_output_strb), 32'(s));
        chk({tag, "_start"}, 32'(bus.sink_start_rqst), 32'(st));
        chk({tag, "_fin"},   32'(bus.sink_fin_rqst), 32'(fin));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rdy"},   32'(bus.src_data_rdy), 32'(1));
        chk({tag, "_avail"}, 32'(bus.sink_word_avail), 32'(0));
        chk({tag, "_data"},  bus.sink_output_data, 32'h0);
        chk({tag, "_strb"},  32'(bus.sink_output_strb), 32'(0));
        chk({tag, "_start"}, 32'(bus.sink_start_rqst), 32'(0));
        chk({tag, "_fin"},   32'(bus.sink_fin_rqst), 32'(0));
    endtask

    initial begin
        bus.src_start_rqst = 1'b0;
        bus.src_data_vld   = 1'b0;
        bus.src_input_data = 8'h00;
        bus.src_fin_rqst   = 1'b0;
        bus.sink_data_rqst = 1'b0;
        cyc();
        cyc();
        check_idle("reset");
        rst = 1'b0;
        cyc();

        // Full 4-byte packet, start pulse in its own cycle
        bus.src_start_rqst = 1'b1;
        cyc();
        bus.src_start_rqst = 1'b0;
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        chk("p1_avail_early", 32'(bus.sink_word_avail), 32'(0));
        send(8'h44, 1'b0, 1'b1);
        check_head("p1", 32'h44332211, 4'b1111, 1'b1, 1'b1);
        pop();
        check_idle("p1_drained");

        // 6-byte packet spanning two words
        send(8'hA0, 1'b1, 1'b0);
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        send(8'hA3, 1'b0, 1'b0);
        check_head("p2w0", 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b0);
        send(8'hA4, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b1);
        check_head("p2w0_held", 32'hA3A2A1A0, 4'b1111, 1'b1, 1'b0);
        pop();
        check_head("p2w1", 32'h0000A5A4, 4'b0011, 1'b0, 1'b1);
        pop();
        check_idle("p2_drained");

        // Single-byte packet: start, valid and fin together
        send(8'h5A, 1'b1, 1'b1);
        check_head("p3", 32'h0000005A, 4'b0001, 1'b1, 1'b1);
        pop();

        // Partial word abandoned by a new start
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        chk("p4_partial_avail", 32'(bus.sink_word_avail), 32'(0));
        send(8'hB0, 1'b1, 1'b0);
        send(8'hB1, 1'b0, 1'b0);
        send(8'hB2, 1'b0, 1'b0);
        chk("p4_avail_early", 32'(bus.sink_word_avail), 32'(0));
        send(8'hB3, 1'b0, 1'b1);
        check_head("p4", 32'hB3B2B1B0, 4'b1111, 1'b1, 1'b1);
        pop();
        chk("p4_drained", 32'(bus.sink_word_avail), 32'(0));

        // Fin without valid is ignored
        send(8'hF0, 1'b1, 1'b0);
        bus.src_fin_rqst = 1'b1;
        cyc();
        bus.src_fin_rqst = 1'b0;
        chk("p5_lone_fin", 32'(bus.sink_word_avail), 32'(0));
        send(8'hF1, 1'b0, 1'b1);
        check_head("p5", 32'h0000F1F0, 4'b0011, 1'b1, 1'b1);
        pop();

        // Backpressure: 12 bytes into a 2-deep FIFO with an idle sink
        bus.src_data_vld   = 1'b1;
        bus.src_start_rqst = 1'b1;
        bus.src_input_data = 8'hC0;
        cyc();
        bus.src_start_rqst = 1'b0;
        for (int i = 1; i < 8; i++) begin
            bus.src_input_data = 8'hC0 + 8'(i);
            cyc();
        end
        chk("bp_rdy_full", 32'(bus.src_data_rdy), 32'(0));
        check_head("bp_w0", 32'hC3C2C1C0, 4'b1111, 1'b1, 1'b0);
        bus.src_input_data = 8'hC8;
        cyc();
        chk("bp_rdy_held", 32'(bus.src_data_rdy), 32'(0));
        check_head("bp_w0_held", 32'hC3C2C1C0, 4'b1111, 1'b1, 1'b0);
        bus.sink_data_rqst = 1'b1;
        cyc();
        bus.sink_data_rqst = 1'b0;
        chk("bp_rdy_after_pop", 32'(bus.src_data_rdy), 32'(1));
        check_head("bp_w1", 32'hC7C6C5C4, 4'b1111, 1'b0, 1'b0);
        cyc();
        bus.src_input_data = 8'hC9;
        cyc();
        bus.src_input_data = 8'hCA;
        cyc();
        bus.src_input_data = 8'hCB;
        bus.src_fin_rqst   = 1'b1;
        cyc();
        bus.src_data_vld   = 1'b0;
        bus.src_fin_rqst   = 1'b0;
        chk("bp_rdy_full2", 32'(bus.src_data_rdy), 32'(0));
        check_head("bp_w1_held", 32'hC7C6C5C4, 4'b1111, 1'b0, 1'b0);
        pop();
        check_head("bp_w2", 32'hCBCAC9C8, 4'b1111, 1'b0, 1'b1);
        pop();
        check_idle("bp_drained");

        // Asynchronous reset with two words buffered and the packet unfinished
        send(8'hD0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) send(8'hD0 + 8'(i), 1'b0, 1'b0);
        check_head("rst_pre", 32'hD3D2D1D0, 4'b1111, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_idle("rst_async");
        cyc();
        rst = 1'b0;
        cyc();
        send(8'hE0, 1'b1, 1'b0);
        send(8'hE1, 1'b0, 1'b0);
        send(8'hE2, 1'b0, 1'b1);
        check_head("post_rst", 32'h00E2E1E0, 4'b0111, 1'b1, 1'b1);
        pop();
        check_idle("post_rst_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
